// File: rtl/m72_mcu_pkg.sv
// Shared types and default mailbox addresses for the MCU/CPU shared-RAM arbiter.
package m72_mcu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_MCU = 1'b1
   } owner_t;

   localparam int          DEF_ADDR_W       = 12;
   localparam logic [11:0] DEF_MCU_INT_ADDR = 12'hFFF;
   localparam logic [11:0] DEF_CPU_INT_ADDR = 12'hFFE;

   // Round-robin pick: on a collision the side that did not own the last access wins.
   function automatic owner_t rr_pick(input logic cpu_req, input logic mcu_req,
                                      input owner_t last_owner);
      owner_t w_pick;
      if (cpu_req && mcu_req) begin
         w_pick = (last_owner == OWNER_MCU) ? OWNER_CPU : OWNER_MCU;
      end else if (cpu_req) begin
         w_pick = OWNER_CPU;
      end else begin
         w_pick = OWNER_MCU;
      end
      return w_pick;
   endfunction

endpackage

// File: rtl/mcu_shared_ram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM (1-cycle read latency),
// with a pair of mailbox bytes that raise/clear cross interrupts.
module mcu_shared_ram_arbiter
   import m72_mcu_pkg::*;
#(
   parameter int                ADDR_W       = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] MCU_INT_ADDR = DEF_MCU_INT_ADDR,
   parameter logic [ADDR_W-1:0] CPU_INT_ADDR = DEF_CPU_INT_ADDR
) (
   input  logic              CLK_32M,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              mcu_req,
   input  logic              mcu_we,
   input  logic [ADDR_W-1:0] mcu_addr,
   input  logic [7:0]        mcu_wdata,
   output logic              mcu_ack,
   output logic [7:0]        mcu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_q,
   output logic              mcu_int,
   output logic              cpu_int,
   output logic              busy
);

   state_t            r_state;
   state_t            w_next_state;
   owner_t            r_owner;
   owner_t            r_last_owner;
   owner_t            w_winner;
   logic              w_any_req;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [7:0]        r_ram_wdata;
   logic              r_ram_we;
   logic              r_cpu_ack;
   logic              r_mcu_ack;
   logic [7:0]        r_cpu_hold;
   logic [7:0]        r_mcu_hold;
   logic              r_mcu_int;
   logic              r_cpu_int;
   logic              r_busy;
   logic              w_cpu_ack_nxt;
   logic              w_mcu_ack_nxt;
   logic              w_mcu_int_nxt;
   logic              w_cpu_int_nxt;
   logic              w_hit_mcu_box;
   logic              w_hit_cpu_box;
   logic              w_cpu_owns;

   assign w_any_req     = cpu_req | mcu_req;
   assign w_winner      = rr_pick(cpu_req, mcu_req, r_last_owner);
   assign w_hit_mcu_box = (r_ram_addr == MCU_INT_ADDR);
   assign w_hit_cpu_box = (r_ram_addr == CPU_INT_ADDR);
   assign w_cpu_owns    = (r_owner == OWNER_CPU);

   // State register.
   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: a fixed three-cycle walk once any request is seen.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = w_any_req ? ACCESS : IDLE;
         ACCESS:  w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Output decode: next ack levels and mailbox flag updates, committed on the ACCESS->RESP edge.
   always_comb begin
      w_cpu_ack_nxt = 1'b0;
      w_mcu_ack_nxt = 1'b0;
      w_mcu_int_nxt = r_mcu_int;
      w_cpu_int_nxt = r_cpu_int;
      case (r_state)
         ACCESS: begin
            w_cpu_ack_nxt = w_cpu_owns;
            w_mcu_ack_nxt = !w_cpu_owns;
            if (w_cpu_owns) begin
               if (r_ram_we && w_hit_mcu_box) begin
                  w_mcu_int_nxt = 1'b1;
               end else begin
                  w_mcu_int_nxt = r_mcu_int;
               end
               if (!r_ram_we && w_hit_cpu_box) begin
                  w_cpu_int_nxt = 1'b0;
               end else begin
                  w_cpu_int_nxt = r_cpu_int;
               end
            end else begin
               // Any MCU touch of its own mailbox acknowledges the interrupt.
               if (w_hit_mcu_box) begin
                  w_mcu_int_nxt = 1'b0;
               end else begin
                  w_mcu_int_nxt = r_mcu_int;
               end
               if (r_ram_we && w_hit_cpu_box) begin
                  w_cpu_int_nxt = 1'b1;
               end else begin
                  w_cpu_int_nxt = r_cpu_int;
               end
            end
         end
         IDLE, RESP: begin
            w_cpu_ack_nxt = 1'b0;
            w_mcu_ack_nxt = 1'b0;
         end
         default: begin
            w_cpu_ack_nxt = 1'b0;
            w_mcu_ack_nxt = 1'b0;
         end
      endcase
   end

   // Grant latch and RAM command registers; the write strobe lives only in ACCESS.
   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         r_owner      <= OWNER_CPU;
         r_last_owner <= OWNER_MCU;
         r_ram_addr   <= {ADDR_W{1'b0}};
         r_ram_wdata  <= 8'h00;
         r_ram_we     <= 1'b0;
      end else if ((r_state == IDLE) && w_any_req) begin
         r_owner      <= w_winner;
         r_last_owner <= w_winner;
         if (w_winner == OWNER_CPU) begin
            r_ram_addr  <= cpu_addr;
            r_ram_wdata <= cpu_wdata;
            r_ram_we    <= cpu_we;
         end else begin
            r_ram_addr  <= mcu_addr;
            r_ram_wdata <= mcu_wdata;
            r_ram_we    <= mcu_we;
         end
      end else begin
         r_ram_we <= 1'b0;
      end
   end

   // Ack pulses, mailbox flags, busy and per-side read-data hold registers.
   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         r_cpu_ack  <= 1'b0;
         r_mcu_ack  <= 1'b0;
         r_mcu_int  <= 1'b0;
         r_cpu_int  <= 1'b0;
         r_busy     <= 1'b0;
         r_cpu_hold <= 8'h00;
         r_mcu_hold <= 8'h00;
      end else begin
         r_cpu_ack <= w_cpu_ack_nxt;
         r_mcu_ack <= w_mcu_ack_nxt;
         r_mcu_int <= w_mcu_int_nxt;
         r_cpu_int <= w_cpu_int_nxt;
         r_busy    <= (w_next_state != IDLE);
         if (r_cpu_ack) begin
            r_cpu_hold <= ram_q;
         end else begin
            r_cpu_hold <= r_cpu_hold;
         end
         if (r_mcu_ack) begin
            r_mcu_hold <= ram_q;
         end else begin
            r_mcu_hold <= r_mcu_hold;
         end
      end
   end

   // RAM data is only valid in RESP, so the owner sees it live and keeps it afterwards.
   assign cpu_rdata = r_cpu_ack ? ram_q : r_cpu_hold;
   assign mcu_rdata = r_mcu_ack ? ram_q : r_mcu_hold;

   assign cpu_ack   = r_cpu_ack;
   assign mcu_ack   = r_mcu_ack;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign ram_we    = r_ram_we;
   assign mcu_int   = r_mcu_int;
   assign cpu_int   = r_cpu_int;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mcu_shared_ram_arbiter.sv
// Directed bench for mcu_shared_ram_arbiter with a behavioural 4 KiB BRAM.
module tb_mcu_shared_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, mcu_req = 1'b0, mcu_we = 1'b0;
   logic [11:0] cpu_addr = 12'h000, mcu_addr = 12'h000;
   logic [7:0]  cpu_wdata = 8'h00, mcu_wdata = 8'h00;
   logic        cpu_ack, mcu_ack, ram_we, mcu_int, cpu_int, busy;
   logic [7:0]  cpu_rdata, mcu_rdata, ram_wdata;
   logic [11:0] ram_addr;
   logic [7:0]  ram_q;
   logic [7:0]  mem [0:4095];

   int errors = 0;
   int checks = 0;
   int cpu_ack_cnt = 0;
   int mcu_ack_cnt = 0;

   always #5 clk = ~clk;

   mcu_shared_ram_arbiter dut (
      .CLK_32M(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
      .mcu_ack(mcu_ack), .mcu_rdata(mcu_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q),
      .mcu_int(mcu_int), .cpu_int(cpu_int), .busy(busy)
   );

   // Single-port BRAM, one-cycle registered read.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
   end

   // Ack pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (cpu_ack) cpu_ack_cnt <= cpu_ack_cnt + 1;
      if (mcu_ack) mcu_ack_cnt <= mcu_ack_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycle count: 1 = cycle in which req is first presented; 99 = no ack within budget.
   task automatic cpu_xfer(input logic we, input logic [11:0] a, input logic [7:0] d,
                           output int cyc, output logic [7:0] rd);
      bit got = 1'b0;
      cyc = 0; rd = 8'h00;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      while (!got && cyc < 20) begin
         @(negedge clk); cyc++;
         if (cpu_ack) begin got = 1'b1; rd = cpu_rdata; end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      if (!got) cyc = 99;
   endtask

   task automatic mcu_xfer(input logic we, input logic [11:0] a, input logic [7:0] d,
                           output int cyc, output logic [7:0] rd);
      bit got = 1'b0;
      cyc = 0; rd = 8'h00;
      mcu_req = 1'b1; mcu_we = we; mcu_addr = a; mcu_wdata = d;
      while (!got && cyc < 20) begin
         @(negedge clk); cyc++;
         if (mcu_ack) begin got = 1'b1; rd = mcu_rdata; end
      end
      @(posedge clk); #1;
      mcu_req = 1'b0;
      if (!got) cyc = 99;
   endtask

   task automatic do_reset();
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int          c1, c2, m0, bad;
      logic [7:0]  r1, r2;
      bit          done;
      int          cpu_max, mcu_max;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", {26'd0, busy, cpu_ack, mcu_ack, ram_we, mcu_int, cpu_int}, 32'd0);
      chk("reset_ram_cmd", {12'd0, ram_addr, ram_wdata}, 32'd0);
      chk("reset_rdata", {16'd0, cpu_rdata, mcu_rdata}, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      cpu_xfer(1'b1, 12'h123, 8'h5A, c1, r1);
      cpu_xfer(1'b1, 12'h020, 8'h77, c1, r1);

      // CPU-only read
      m0 = mcu_ack_cnt;
      cpu_xfer(1'b0, 12'h123, 8'h00, c1, r1);
      chk("cpu_read_lat", c1, 32'd3);
      chk("cpu_read_data", {24'd0, r1}, 32'h5A);
      chk("cpu_read_no_mcu_ack", mcu_ack_cnt - m0, 32'd0);

      // Collision right after reset: CPU first
      do_reset();
      fork
         cpu_xfer(1'b1, 12'h010, 8'h11, c1, r1);
         mcu_xfer(1'b0, 12'h020, 8'h00, c2, r2);
      join
      chk("coll1_cpu_lat", c1, 32'd3);
      chk("coll1_mcu_lat", c2, 32'd6);
      chk("coll1_mcu_data", {24'd0, r2}, 32'h77);
      cpu_xfer(1'b0, 12'h010, 8'h00, c1, r1);
      chk("coll1_write_landed", {24'd0, r1}, 32'h11);

      // CPU owned last, so the next collision goes to the MCU
      fork
         cpu_xfer(1'b0, 12'h020, 8'h00, c1, r1);
         mcu_xfer(1'b0, 12'h123, 8'h00, c2, r2);
      join
      chk("coll2_mcu_lat", c2, 32'd3);
      chk("coll2_cpu_lat", c1, 32'd6);
      chk("coll2_data", {16'd0, r1, r2}, 32'h775A);

      // Mailbox towards the MCU
      cpu_xfer(1'b1, 12'hEFF, 8'h01, c1, r1);
      chk("near_box_no_int", {30'd0, mcu_int, cpu_int}, 32'd0);
      cpu_xfer(1'b1, 12'hFFF, 8'h01, c1, r1);
      chk("mcu_int_set", {31'd0, mcu_int}, 32'd1);
      cpu_xfer(1'b0, 12'hFFF, 8'h00, c1, r1);
      chk("mcu_int_cpu_read_keeps", {31'd0, mcu_int}, 32'd1);
      mcu_xfer(1'b0, 12'hFFF, 8'h00, c2, r2);
      chk("mcu_int_clr", {31'd0, mcu_int}, 32'd0);
      chk("mcu_box_data", {24'd0, r2}, 32'h01);

      // Mailbox towards the CPU
      mcu_xfer(1'b1, 12'hFFE, 8'hA5, c2, r2);
      chk("cpu_int_set", {31'd0, cpu_int}, 32'd1);
      cpu_xfer(1'b1, 12'hFFE, 8'h5B, c1, r1);
      chk("cpu_int_cpu_write_keeps", {31'd0, cpu_int}, 32'd1);
      cpu_xfer(1'b0, 12'hFFE, 8'h00, c1, r1);
      chk("cpu_int_clr", {31'd0, cpu_int}, 32'd0);
      chk("cpu_box_data", {24'd0, r1}, 32'h5B);

      // Streaming MCU writes with a periodic CPU reader
      done = 1'b0; cpu_max = 0; mcu_max = 0;
      fork
         begin
            int          mc;
            logic [7:0]  mr;
            for (int i = 0; i < 4096; i++) begin
               mcu_xfer(1'b1, i[11:0], i[7:0] ^ 8'h3C, mc, mr);
               if (mc > mcu_max) mcu_max = mc;
            end
            done = 1'b1;
         end
         begin
            int          cc;
            logic [7:0]  cr;
            while (!done) begin
               cpu_xfer(1'b0, 12'h123, 8'h00, cc, cr);
               if (cc > cpu_max) cpu_max = cc;
               repeat (7) begin @(posedge clk); #1; end
            end
         end
      join
      chk("stream_mcu_lat", {31'd0, (mcu_max <= 6)}, 32'd1);
      chk("stream_cpu_lat", {31'd0, (cpu_max <= 6)}, 32'd1);
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
         logic [11:0] ia;
         ia = i[11:0];
         if (mem[ia] !== (ia[7:0] ^ 8'h3C)) bad++;
      end
      chk("stream_ram", bad, 32'd0);

      // Reset during ACCESS
      cpu_xfer(1'b1, 12'hFFF, 8'h02, c1, r1);
      mcu_xfer(1'b1, 12'hFFE, 8'h03, c2, r2);
      chk("pre_reset_flags", {30'd0, mcu_int, cpu_int}, 32'd3);
      m0 = cpu_ack_cnt;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'hEE;
      @(posedge clk);
      @(negedge clk);
      chk("access_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_state", {27'd0, busy, mcu_int, cpu_int, ram_we, cpu_ack}, 32'd0);
      cpu_req = 1'b0;
      #2 reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_ack", cpu_ack_cnt - m0, 32'd0);
      chk("abort_flags", {30'd0, mcu_int, cpu_int}, 32'd0);
      @(posedge clk); #1;
      cpu_xfer(1'b0, 12'h123, 8'h00, c1, r1);
      chk("post_reset_lat", c1, 32'd3);
      chk("post_reset_data", {24'd0, r1}, 32'h1F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mcu_shared_ram_arbiter.md
MCU_SHARED_RAM_ARBITER -- requirements
Module: mcu_shared_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, shared RAM address width (4 KiB).
REQ-002 SHALL have parameter MCU_INT_ADDR, default 12'hFFF, mailbox byte; a CPU write sets the MCU interrupt and an MCU access clears it.
REQ-003 SHALL have parameter CPU_INT_ADDR, default 12'hFFE, mailbox byte; an MCU write sets the CPU interrupt and a CPU read clears it.
REQ-004 SHALL have port CLK_32M, input, 1, sole clock; one clock, and reset is asynchronous and active-low.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, ADDR_W), cpu_wdata (input, 8), cpu_ack (output, 1), cpu_rdata (output, 8); main-CPU requester.
REQ-007 SHALL have ports mcu_req, mcu_we, mcu_addr, mcu_wdata, mcu_ack, mcu_rdata with identical widths; MCU or emulator requester.
REQ-008 SHALL have ports ram_addr (output, ADDR_W), ram_wdata (output, 8), ram_we (output, 1), ram_q (input, 8); single-port BRAM with 1-cycle read latency.
REQ-009 SHALL have ports mcu_int (output, 1) and cpu_int (output, 1), mailbox interrupt levels.
REQ-010 SHALL have port busy (output, 1), high whenever the state is not IDLE.

Function
REQ-011 Handshake: a requester holds req, we, addr and wdata stable until its ack pulses high for exactly one cycle, and deasserts req or presents a new request in the cycle after ack.
REQ-012 States: IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high, ACCESS->RESP always, RESP->IDLE always.
REQ-013 In the IDLE->ACCESS transition, the winner is latched into owner and ram_addr, ram_wdata and ram_we are registered from the winner; ram_we is high only during ACCESS.
REQ-014 In RESP, the owner's ack = 1 and rdata = ram_q; the other requester's ack stays 0 and its rdata holds its last value.
REQ-015 Latency: ack is asserted exactly 3 cycles after req is first sampled high when the RAM is uncontended; one transaction per 3 cycles at most.
REQ-016 Arbitration: round-robin; a last_owner flag toggles priority, so when both requests are high in IDLE, the requester that did not own the previous transaction wins; after reset, CPU has priority.
REQ-017 A requester that loses arbitration is granted in the immediately following IDLE, so its worst-case wait is 6 cycles.
REQ-018 A CPU write to MCU_INT_ADDR sets mcu_int in the RESP cycle, and the byte is also written to RAM.
REQ-019 Any MCU read or write of MCU_INT_ADDR clears mcu_int in RESP.
REQ-020 An MCU write to CPU_INT_ADDR sets cpu_int in RESP, and a CPU read of CPU_INT_ADDR clears it in RESP.
REQ-021 Set and clear of the same flag cannot coincide, because only one transaction is in flight; no other address affects the flags.
REQ-022 Address compare uses the full ADDR_W bits; there is no wrap or aliasing.
REQ-023 A req that drops before ack is not supported, and the transaction still completes.

Reset
REQ-024 When reset_n is low, the block SHALL asynchronously force: state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, cpu_ack=0, mcu_ack=0, cpu_rdata=0, mcu_rdata=0, mcu_int=0, cpu_int=0, last_owner=MCU (so CPU wins first).
REQ-025 A reset asserted mid-transaction SHALL abort it with no ack and no flag change; a write in ACCESS may or may not reach the RAM.

Structure
REQ-026 Package m72_mcu_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), the owner enum (OWNER_CPU, OWNER_MCU), and the default mailbox addresses.
REQ-027 No sub-module SHALL be used; the BRAM is instantiated by the parent.

Verification
REQ-028 CPU-only read: the bench SHALL preload 0x123=0x5A, then raise cpu_req with we=0 and addr=0x123 -> cpu_ack high on cycle 3 with cpu_rdata=0x5A, and mcu_ack stays 0.
REQ-029 Simultaneous requests after reset (CPU writes 0x010=0x11, MCU reads 0x020) -> CPU acked at cycle 3 and MCU at cycle 6; a repeat collision -> MCU first.
REQ-030 Mailbox: a CPU write of 0xFFF=0x01 -> mcu_int=1; an MCU read of 0xFFF -> mcu_int=0 and mcu_rdata=0x01.
REQ-031 Mailbox: an MCU write of 0xFFE=0xA5 -> cpu_int=1; a CPU write of 0xFFE leaves cpu_int=1; a CPU read of 0xFFE -> cpu_int=0.
REQ-032 Streaming: the MCU issues 4096 back-to-back writes 0x000-0xFFF while the CPU requests every 10 cycles -> every request is acked within 6 cycles, and the RAM contents match.
REQ-033 Reset: reset_n is pulsed low during ACCESS -> no ack, state=IDLE, both flags 0, and the next request is acked after 3 cycles.
